// File: rtl/icache_axi_rd_bridge_pkg.sv
// -----------------------------------------------------------------------------
// icache_axi_rd_bridge_pkg
// Shared definitions for the instruction-cache AXI read bridge: the AXI
// encodings the bridge drives or checks, the bridge FSM state encoding, the
// return-path payload width and the per-beat response checker.
// -----------------------------------------------------------------------------
package icache_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Return payload carried through the optional buffer: {last, data}
  localparam int unsigned RET_PAYLOAD_W = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_RD   = 2'd2
  } bridge_state_e;

  // Flags an accepted R beat that is inconsistent with the burst we issued:
  // bad response, foreign ID, rlast early/late relative to the beat count.
  function automatic logic beat_err(
    input logic [1:0] resp,
    input logic [3:0] id,
    input logic [3:0] exp_id,
    input logic       last,
    input logic [7:0] cnt,
    input logic [7:0] len
  );
    return (resp != AXI_RESP_OKAY) ||
           (id != exp_id) ||
           (last && (cnt != len)) ||
           (!last && (cnt == len));
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
// One-entry registered buffer with valid/ready on both sides. Accepts a new
// entry whenever it is empty or its current entry is being drained, so a
// continuous stream passes with one cycle of latency and no bubbles.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   i_valid/o_ready      upstream handshake, i_data payload in
//   o_valid/i_ready      downstream handshake, o_data payload out
// -----------------------------------------------------------------------------
module rd_skid_buf
  import icache_axi_rd_bridge_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [RET_PAYLOAD_W-1:0] i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [RET_PAYLOAD_W-1:0] o_data
);

  logic                     r_valid;
  logic [RET_PAYLOAD_W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Entry register; payload is zeroed when empty so last/data read as 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= {RET_PAYLOAD_W{1'b0}};
    end else if (o_ready) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : {RET_PAYLOAD_W{1'b0}};
    end
  end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// icache_axi_rd_bridge
// Converts a cache line-fill request (address + AXI-encoded length) into one
// AXI4 INCR read burst of 4-byte beats and returns the beats to the cache in
// order. Checks every accepted R beat and pulses rd_err on a bad response,
// foreign ID or rlast/beat-count disagreement; the burst always ends on rlast.
//
// Build option RD_SKID_BUF_EN:
//   defined   - return beats pass through a one-entry register (rd_skid_buf),
//               rvalid -> ret_valid latency of one cycle.
//   undefined - combinational pass-through, zero latency.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   r_req/r_rdy, r_addr, r_length  cache request and acceptance
//   r_data_ready                   cache can take a return beat
//   ret_valid, ret_last, r_data_AXI return beat to the cache
//   arid..arvalid, arready         AXI read address channel
//   rid..rvalid, rready            AXI read data channel
//   rd_err                         one-cycle error pulse per bad beat
// -----------------------------------------------------------------------------
module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        r_req,
  input  logic [31:0] r_addr,
  input  logic [7:0]  r_length,
  output logic        r_rdy,
  input  logic        r_data_ready,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] r_data_AXI,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  bridge_state_e r_state;
  bridge_state_e w_state_nxt;
  logic          r_acc_rdy;
  logic [31:0]   r_cap_addr;
  logic [7:0]    r_cap_len;
  logic [7:0]    r_beat_cnt;
  logic          w_in_rd;
  logic          w_accept;
  logic          w_ar_hs;
  logic          w_r_hs;

  assign w_in_rd  = (r_state == ST_RD);
  assign w_accept = r_req && r_acc_rdy;
  assign w_ar_hs  = arvalid && arready;
  assign w_r_hs   = rvalid && rready;

  assign r_rdy   = r_acc_rdy;
  assign arvalid = (r_state == ST_AR);
  assign arid    = AXI_ID;
  assign araddr  = r_cap_addr;
  assign arlen   = r_cap_len;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign rd_err  = w_r_hs && beat_err(rresp, rid, AXI_ID, rlast, r_beat_cnt, r_cap_len);

  // Next-state logic; the burst ends on rlast even if it arrives early
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_AR;
        else          w_state_nxt = ST_IDLE;
      end
      ST_AR: begin
        if (arready) w_state_nxt = ST_RD;
        else         w_state_nxt = ST_AR;
      end
      ST_RD: begin
        if (w_r_hs && rlast) w_state_nxt = ST_IDLE;
        else                 w_state_nxt = ST_RD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; r_rdy is registered from the next state so it stays low
  // during reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_acc_rdy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc_rdy <= (w_state_nxt == ST_IDLE);
    end
  end

  // Request capture; held stable on the AR channel until the next acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cap_addr <= 32'd0;
      r_cap_len  <= 8'd0;
    end else if (w_accept) begin
      r_cap_addr <= r_addr;
      r_cap_len  <= r_length;
    end
  end

  // Beat counter: cleared when the burst enters RD, counts accepted R beats
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat_cnt <= 8'd0;
    end else if (w_ar_hs) begin
      r_beat_cnt <= 8'd0;
    end else if (w_r_hs) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

`ifdef RD_SKID_BUF_EN
  logic                     w_buf_in_ready;
  logic [RET_PAYLOAD_W-1:0] w_buf_out;

  rd_skid_buf u_rd_skid_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (w_in_rd && rvalid),
    .o_ready (w_buf_in_ready),
    .i_data  ({rlast, rdata}),
    .o_valid (ret_valid),
    .i_ready (r_data_ready),
    .o_data  (w_buf_out)
  );

  assign rready     = w_in_rd && w_buf_in_ready;
  assign ret_last   = w_buf_out[32];
  assign r_data_AXI = w_buf_out[31:0];
`else
  assign rready     = w_in_rd && r_data_ready;
  assign ret_valid  = w_in_rd && rvalid;
  assign ret_last   = ret_valid && rlast;
  assign r_data_AXI = ret_valid ? rdata : 32'd0;
`endif

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// tb_icache_axi_rd_bridge
// Directed bench for icache_axi_rd_bridge with a small AXI slave model and a
// return-beat monitor. Works for both RD_SKID_BUF_EN builds.
// -----------------------------------------------------------------------------
module tb_icache_axi_rd_bridge;

`ifdef RD_SKID_BUF_EN
  localparam int RET_LAT = 1;
`else
  localparam int RET_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        r_req;
  logic [31:0] r_addr;
  logic [7:0]  r_length;
  logic        r_rdy;
  logic        r_data_ready;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] r_data_AXI;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        rd_err;

  int n_checks = 0;
  int n_fail   = 0;

  // slave model configuration
  int cfg_ar_delay   = 1;
  int cfg_last_beat  = -1;
  int cfg_bad_beat   = -1;
  bit cfg_rdr_toggle = 1'b0;

  // monitor results
  logic [31:0] mon_data[$];
  logic        mon_last[$];
  int          err_idx[$];
  int          mon_rhs   = 0;
  int          stray_err = 0;

  always #5 clk = ~clk;

  icache_axi_rd_bridge #(.AXI_ID(4'd0)) dut (
    .clk(clk), .rstn(rstn), .r_req(r_req), .r_addr(r_addr), .r_length(r_length),
    .r_rdy(r_rdy), .r_data_ready(r_data_ready), .ret_valid(ret_valid),
    .ret_last(ret_last), .r_data_AXI(r_data_AXI), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .rd_err(rd_err)
  );

  function automatic logic [31:0] beat_word(input logic [31:0] base, input int beat);
    return (base + (32'(beat) << 2)) ^ 32'hDEAD_0000;
  endfunction

  task automatic drive_beat(input logic [31:0] base, input int beat, input int last_idx);
    rvalid = 1'b1;
    rid    = 4'd0;
    rdata  = beat_word(base, beat);
    rlast  = (beat == last_idx);
    rresp  = (beat == cfg_bad_beat) ? 2'b10 : 2'b00;
  endtask

  // AXI slave: samples handshakes at negedge, drives at posedge+1
  initial begin : axi_slave
    bit          ph;
    bit          s_ar_hs;
    bit          s_r_hs;
    int          ar_cnt;
    int          beat;
    int          last_idx;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [15:0] rdr_pat;
    arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00;
    rlast = 1'b0; r_data_ready = 1'b1;
    ph = 1'b0; ar_cnt = 0; beat = 0; last_idx = 0; s_addr = 32'd0; s_len = 8'd0;
    rdr_pat = 16'hA6CB;
    forever begin
      @(negedge clk);
      s_ar_hs = arvalid && arready;
      s_r_hs  = rvalid && rready;
      if (s_ar_hs) begin
        s_addr = araddr;
        s_len  = arlen;
      end
      @(posedge clk);
      #1;
      if (cfg_rdr_toggle) begin
        r_data_ready = rdr_pat[0];
        rdr_pat = {rdr_pat[0], rdr_pat[15:1]};
      end else begin
        r_data_ready = 1'b1;
      end
      if (!rstn) begin
        ph = 1'b0; ar_cnt = 0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      end else if (!ph) begin
        if (s_ar_hs) begin
          arready  = 1'b0;
          ar_cnt   = 0;
          ph       = 1'b1;
          beat     = 0;
          last_idx = (cfg_last_beat >= 0) ? cfg_last_beat : int'(s_len);
          drive_beat(s_addr, beat, last_idx);
        end else if (arvalid) begin
          arready = (ar_cnt == cfg_ar_delay - 1);
          ar_cnt++;
        end else begin
          arready = 1'b0;
        end
      end else if (s_r_hs) begin
        if (rlast) begin
          rvalid = 1'b0; rlast = 1'b0; ph = 1'b0;
        end else begin
          beat++;
          drive_beat(s_addr, beat, last_idx);
        end
      end
    end
  end

  // Monitor: return beats taken by the cache, rd_err pulses per accepted beat
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (ret_valid && r_data_ready) begin
          mon_data.push_back(r_data_AXI);
          mon_last.push_back(ret_last);
        end
        if (rvalid && rready) begin
          if (rd_err) err_idx.push_back(mon_rhs);
          mon_rhs++;
        end else if (rd_err) begin
          stray_err++;
        end
      end
    end
  end

  task automatic clear_mon();
    mon_data.delete();
    mon_last.delete();
    err_idx.delete();
    mon_rhs   = 0;
    stray_err = 0;
  endtask

  // Issues one request and waits until nbeats were returned and r_rdy is back
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                           output int ar_cyc, output bit ar_ok, output bit done);
    bit acc;
    acc = 1'b0; ar_cyc = 0; ar_ok = 1'b1; done = 1'b0;
    @(posedge clk);
    #1;
    clear_mon();
    r_req = 1'b1; r_addr = addr; r_length = len;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (r_req && r_rdy) acc = 1'b1;
      if (arvalid) begin
        ar_cyc++;
        if (araddr !== addr || arlen !== len || arsize !== 3'b010 ||
            arburst !== 2'b01 || arid !== 4'd0) ar_ok = 1'b0;
      end
      if (acc && !r_req && r_rdy && mon_data.size() >= nbeats) done = 1'b1;
      @(posedge clk);
      #1;
      if (acc) r_req = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (r_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_r_rdy got=%b exp=0", r_rdy); end
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got=%b exp=0", rready); end
    n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ret_valid got=%b exp=0", ret_valid); end
    n_checks++; if (ret_last !== 1'b0) begin n_fail++; $display("FAIL reset_ret_last got=%b exp=0", ret_last); end
    n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
    n_checks++; if (r_data_AXI !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", r_data_AXI); end
    n_checks++; if (araddr !== 32'd0) begin n_fail++; $display("FAIL reset_araddr got=%h exp=0", araddr); end
    n_checks++; if (arlen !== 8'd0) begin n_fail++; $display("FAIL reset_arlen got=%h exp=0", arlen); end
    #2 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (r_rdy !== 1'b1) begin n_fail++; $display("FAIL release_r_rdy got=%b exp=1", r_rdy); end
  endtask

  task automatic test_burst16();
    int ar_cyc; bit ar_ok; bit done; int bad;
    cfg_ar_delay = 3; cfg_rdr_toggle = 1'b0; cfg_last_beat = -1; cfg_bad_beat = -1;
    run_burst(32'h1C00_0040, 8'd15, 16, ar_cyc, ar_ok, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL b16_done got=0 exp=1 beats=%0d", mon_data.size()); end
    n_checks++; if (ar_cyc != 3) begin n_fail++; $display("FAIL b16_ar_cycles got=%0d exp=3", ar_cyc); end
    n_checks++; if (!ar_ok) begin n_fail++; $display("FAIL b16_ar_fields got=bad exp=1C000040/15/2/1/0"); end
    n_checks++; if (mon_data.size() != 16) begin n_fail++; $display("FAIL b16_count got=%0d exp=16", mon_data.size()); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= mon_data.size() || mon_data[i] !== beat_word(32'h1C00_0040, i)) begin
        n_fail++; $display("FAIL b16_data[%0d] got=%h exp=%h", i,
                           (i < mon_data.size()) ? mon_data[i] : 32'hx, beat_word(32'h1C00_0040, i));
      end
    end
    bad = 0;
    for (int i = 0; i < mon_last.size(); i++) if (mon_last[i] !== (i == 15)) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b16_last got=%0d misplaced exp=0", bad); end
    n_checks++; if (err_idx.size() != 0 || stray_err != 0) begin n_fail++; $display("FAIL b16_rd_err got=%0d pulses exp=0", err_idx.size() + stray_err); end
    cfg_ar_delay = 1;
  endtask

  task automatic test_single();
    int cyc_rhs; int cyc_ret; logic got_last; logic [31:0] got_data; logic rdy_hist[0:40]; bit acc; int k;
    cfg_ar_delay = 1; cfg_rdr_toggle = 1'b0; cfg_last_beat = -1; cfg_bad_beat = -1;
    cyc_rhs = -1; cyc_ret = -1; got_last = 1'b0; got_data = 32'd0; acc = 1'b0;
    @(posedge clk);
    #1;
    clear_mon();
    r_req = 1'b1; r_addr = 32'h1FAF_0008; r_length = 8'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rdy_hist[c] = r_rdy;
      if (r_req && r_rdy) acc = 1'b1;
      if (rvalid && rready && cyc_rhs < 0) cyc_rhs = c;
      if (ret_valid && cyc_ret < 0) begin
        cyc_ret = c; got_last = ret_last; got_data = r_data_AXI;
      end
      @(posedge clk);
      #1;
      if (acc) r_req = 1'b0;
    end
    k = (cyc_rhs < 0) ? 0 : cyc_rhs;
    n_checks++; if (cyc_rhs != 2) begin n_fail++; $display("FAIL single_r_cycle got=%0d exp=2", cyc_rhs); end
    n_checks++; if (cyc_ret - cyc_rhs != RET_LAT || cyc_ret < 0) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", cyc_ret - cyc_rhs, RET_LAT); end
    n_checks++; if (got_last !== 1'b1) begin n_fail++; $display("FAIL single_ret_last got=%b exp=1", got_last); end
    n_checks++; if (got_data !== beat_word(32'h1FAF_0008, 0)) begin n_fail++; $display("FAIL single_data got=%h exp=%h", got_data, beat_word(32'h1FAF_0008, 0)); end
    n_checks++; if (rdy_hist[k] !== 1'b0) begin n_fail++; $display("FAIL single_rdy_on_beat got=%b exp=0", rdy_hist[k]); end
    n_checks++; if (rdy_hist[k + 1] !== 1'b1) begin n_fail++; $display("FAIL single_rdy_after got=%b exp=1", rdy_hist[k + 1]); end
    n_checks++; if (mon_data.size() != 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", mon_data.size()); end
  endtask

  task automatic test_backpressure();
    int ar_cyc; bit ar_ok; bit done; int bad;
    cfg_ar_delay = 1; cfg_rdr_toggle = 1'b1; cfg_last_beat = -1; cfg_bad_beat = -1;
    run_burst(32'h0000_2000, 8'd15, 16, ar_cyc, ar_ok, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL bp_done got=0 exp=1 beats=%0d", mon_data.size()); end
    n_checks++; if (mon_data.size() != 16) begin n_fail++; $display("FAIL bp_count got=%0d exp=16", mon_data.size()); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= mon_data.size() || mon_data[i] !== beat_word(32'h0000_2000, i)) begin
        n_fail++; $display("FAIL bp_data[%0d] got=%h exp=%h", i,
                           (i < mon_data.size()) ? mon_data[i] : 32'hx, beat_word(32'h0000_2000, i));
      end
    end
    bad = 0;
    for (int i = 0; i < mon_last.size(); i++) if (mon_last[i] !== (i == 15)) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_last got=%0d misplaced exp=0", bad); end
    cfg_rdr_toggle = 1'b0;
  endtask

  task automatic test_early_last();
    int ar_cyc; bit ar_ok; bit done; int bad;
    cfg_ar_delay = 1; cfg_rdr_toggle = 1'b0; cfg_last_beat = 7; cfg_bad_beat = -1;
    run_burst(32'h1C00_0100, 8'd15, 8, ar_cyc, ar_ok, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL early_done_idle got=0 exp=1 beats=%0d", mon_data.size()); end
    n_checks++; if (mon_data.size() != 8) begin n_fail++; $display("FAIL early_count got=%0d exp=8", mon_data.size()); end
    n_checks++; if (err_idx.size() != 1 || stray_err != 0) begin n_fail++; $display("FAIL early_err_pulses got=%0d exp=1", err_idx.size() + stray_err); end
    n_checks++; if (err_idx.size() > 0 && err_idx[0] != 7) begin n_fail++; $display("FAIL early_err_beat got=%0d exp=7", err_idx[0]); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= mon_data.size() || mon_data[i] !== beat_word(32'h1C00_0100, i)) begin
        n_fail++; $display("FAIL early_data[%0d] got=%h exp=%h", i,
                           (i < mon_data.size()) ? mon_data[i] : 32'hx, beat_word(32'h1C00_0100, i));
      end
    end
    bad = 0;
    for (int i = 0; i < mon_last.size(); i++) if (mon_last[i] !== (i == 7)) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL early_last got=%0d misplaced exp=0", bad); end
    cfg_last_beat = -1;
  endtask

  task automatic test_bad_resp();
    int ar_cyc; bit ar_ok; bit done;
    cfg_ar_delay = 2; cfg_rdr_toggle = 1'b1; cfg_last_beat = -1; cfg_bad_beat = 3;
    run_burst(32'h1C00_0200, 8'd15, 16, ar_cyc, ar_ok, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL resp_done got=0 exp=1 beats=%0d", mon_data.size()); end
    n_checks++; if (ar_cyc != 2) begin n_fail++; $display("FAIL resp_ar_cycles got=%0d exp=2", ar_cyc); end
    n_checks++; if (mon_data.size() != 16) begin n_fail++; $display("FAIL resp_count got=%0d exp=16", mon_data.size()); end
    n_checks++; if (err_idx.size() != 1 || stray_err != 0) begin n_fail++; $display("FAIL resp_err_pulses got=%0d exp=1", err_idx.size() + stray_err); end
    n_checks++; if (err_idx.size() > 0 && err_idx[0] != 3) begin n_fail++; $display("FAIL resp_err_beat got=%0d exp=3", err_idx[0]); end
    n_checks++; if (mon_data.size() > 3 && mon_data[3] !== beat_word(32'h1C00_0200, 3)) begin n_fail++; $display("FAIL resp_data3 got=%h exp=%h", mon_data[3], beat_word(32'h1C00_0200, 3)); end
    cfg_bad_beat = -1; cfg_rdr_toggle = 1'b0; cfg_ar_delay = 1;
  endtask

  task automatic test_reset_mid();
    bit started; bit acc; bit done;
    cfg_ar_delay = 1; cfg_rdr_toggle = 1'b0; cfg_last_beat = -1; cfg_bad_beat = -1;
    started = 1'b0; acc = 1'b0; done = 1'b0;
    @(posedge clk);
    #1;
    clear_mon();
    r_req = 1'b1; r_addr = 32'h1C00_0300; r_length = 8'd15;
    for (int c = 0; c < 100 && !started; c++) begin
      @(negedge clk);
      if (r_req && r_rdy) acc = 1'b1;
      if (mon_rhs >= 6) started = 1'b1;
      if (!started) begin
        @(posedge clk);
        #1;
        if (acc) r_req = 1'b0;
      end
    end
    n_checks++; if (!started) begin n_fail++; $display("FAIL mid_beats got=%0d exp>=6", mon_rhs); end
    r_req = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL mid_arvalid got=%b exp=0", arvalid); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL mid_rready got=%b exp=0", rready); end
    n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ret_valid got=%b exp=0", ret_valid); end
    n_checks++; if (r_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_r_rdy got=%b exp=0", r_rdy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_mon();
    r_req = 1'b1; r_addr = 32'h1FAF_0010; r_length = 8'd3;
    #2 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (r_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy_release got=%b exp=1", r_rdy); end
    @(posedge clk);
    #1;
    r_req = 1'b0;
    @(negedge clk);
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h1FAF_0010) begin n_fail++; $display("FAIL mid_new_ar got=%b/%h exp=1/1faf0010", arvalid, araddr); end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (mon_data.size() >= 4 && r_rdy) done = 1'b1;
    end
    n_checks++; if (mon_data.size() != 4) begin n_fail++; $display("FAIL mid_new_count got=%0d exp=4", mon_data.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= mon_data.size() || mon_data[i] !== beat_word(32'h1FAF_0010, i)) begin
        n_fail++; $display("FAIL mid_new_data[%0d] got=%h exp=%h", i,
                           (i < mon_data.size()) ? mon_data[i] : 32'hx, beat_word(32'h1FAF_0010, i));
      end
    end
  endtask

  initial begin : main
    rstn = 1'b0; r_req = 1'b0; r_addr = 32'd0; r_length = 8'd0;
    test_reset();
    test_burst16();
    test_single();
    test_backpressure();
    test_early_last();
    test_bad_resp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
